turn_controller: RTL
====================

Name: turn_controller

Overview:
- Sequences the 30-second timer for the two-player subtract-square game.
- Each turn: arms the timer and picks its tick speed.
- Reacts to a player move or a timeout, alternates the active player and runs the post-timeout "loading" pause.
- Sits between game logic/input handling and the timer instance in the top module.

Parameters:
- ROUNDS_PER_SPEEDUP, default 4: number of completed moves after which the timer switches to the fast speed.
- LOAD_CYCLES, default 100_000_000: clock cycles spent in the loading pause (2 s at 50 MHz).
- GUARD_CYCLES, default 2: cycles after arming during which time_up is ignored.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous reset, active-high (asserted = 1).
- start  in  1  one-cycle pulse; starts or restarts a game.
- move_valid  in  1  one-cycle pulse; the active player made a legal move.
- game_over_in  in  1  level; game logic reports the pile is exhausted.
- time_up  in  1  from the timer; high while the timer is held in reset and when the count reaches 0.
- timer_reset  out  1  drives the timer's reset input; active-high.
- timer_freq  out  2  drives the timer's frequency input: 00 slow, 11 fast, 01 hold.
- player  out  1  active player (0/1).
- loading  out  1  high during the loading pause.
- forfeit  out  1  one-cycle pulse on a timeout.
- fast_mode  out  1  high once the speed-up threshold is reached.
- game_done  out  1  high in the DONE state.

Behaviour:
- Reset values: state=IDLE, timer_reset=1, timer_freq=01, player=0, loading=0, forfeit=0, fast_mode=0, game_done=0. move_cnt=0, guard=0, load_cnt=0.
- Outputs timer_reset, timer_freq, loading and game_done are decoded from state. player, forfeit and fast_mode are registered.
- IDLE: timer_reset=1, freq=01. start -> ARM; the same transition clears move_cnt, fast_mode and player.
- ARM (exactly 1 cycle): timer_reset=1, freq=01. Loads guard=GUARD_CYCLES. -> PLAY.
- PLAY: timer_reset=0; freq=11 if fast_mode else 00; guard decrements to 0. Priority per cycle, highest first:
  1. game_over_in -> DONE.
  2. move_valid -> toggle player; move_cnt saturating increment; fast_mode set when move_cnt+1 >= ROUNDS_PER_SPEEDUP; -> ARM. The timer restarts at 30.
  3. time_up with guard==0 -> forfeit pulse (1 cycle); toggle player; -> LOAD. move_cnt is unchanged.
- time_up while guard!=0 is ignored. This masks the timer's reset-time time_up.
- LOAD: loading=1, timer_reset=1, freq=01. load_cnt counts LOAD_CYCLES-1 down to 0; at 0 -> ARM.
  - move_valid is ignored in LOAD.
  - game_over_in in LOAD -> DONE.
- DONE: game_done=1, timer_reset=1, freq=01; player holds. start -> ARM with the same clears as IDLE->ARM.
- start in PLAY, ARM or LOAD: restarts the game. Clears counters and player -> ARM. Has lower priority than game_over_in, higher than move_valid/time_up.
- Asynchronous reset at any time returns to the reset values within the same cycle, regardless of state.
- move_cnt width: $clog2(ROUNDS_PER_SPEEDUP+1); saturates, never wraps. fast_mode is sticky until start or reset.

Optional Feature:
- Macro: STRIKE_LIMIT_EN.
- With the macro defined:
  - Adds per-player 2-bit strike counters, each incremented on that player's forfeit and cleared on start.
  - The third strike goes directly to DONE instead of LOAD.
  - Adds output winner (1 bit) = the other player, valid while game_done=1.
- Without the macro: no strike logic, no winner port; a timeout always goes to LOAD.

Decomposition:
- Package turn_ctrl_pkg holds:
  - State enum: IDLE, ARM, PLAY, LOAD, DONE.
  - Frequency constants: FREQ_SLOW=2'b00, FREQ_FAST=2'b11, FREQ_HOLD=2'b01.
- One sub-module, load_timer: a loadable down-counter with a done flag, 28-bit width derived from LOAD_CYCLES. Used for the LOAD pause.
- The guard counter stays inline.

Test Plan:
- Reset then start: ARM lasts 1 cycle (timer_reset=1), then PLAY with timer_reset=0, freq=00, player=0.
- time_up held high during the first 2 PLAY cycles (guard) -> no forfeit, stays in PLAY. time_up at cycle 3 -> forfeit pulse, player=1, loading=1 for LOAD_CYCLES (set to 10 in the bench), then ARM.
- 4 move_valid pulses separated by 5 cycles -> player toggles each time; fast_mode=1 after the 4th; next PLAY shows freq=11.
- move_valid and time_up in the same PLAY cycle -> move wins: no forfeit, ARM next, move_cnt incremented.
- game_over_in during LOAD -> DONE, game_done=1, freq=01. Then start -> ARM with player=0 and fast_mode=0.
- reset_n asserted mid-LOAD -> immediately IDLE, loading=0, timer_reset=1. With STRIKE_LIMIT_EN: 3 forfeits by player 0 -> DONE, winner=1.

Source files
------------

// File: rtl/turn_controller_pkg.sv
// Shared types and constants for turn_controller: FSM states, timer frequency codes
// and the width helper for the loading-pause counter.
package turn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    PLAY,
    LOAD,
    DONE
  } state_t;

  localparam logic [1:0] FREQ_SLOW = 2'b00;
  localparam logic [1:0] FREQ_FAST = 2'b11;
  localparam logic [1:0] FREQ_HOLD = 2'b01;

  // One spare bit above the minimum so LOAD_CYCLES-1 always fits (28 bits at 100M).
  function automatic int unsigned load_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/turn_controller_load_timer.sv
// load_timer: loadable down-counter that stops at zero and flags done.
// Times the post-timeout loading pause of turn_controller.
module load_timer #(
  parameter int unsigned WIDTH = 28
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/turn_controller.sv
// turn_controller: sequences the 30 s move timer for the subtract-square game.
// Optional macro STRIKE_LIMIT_EN adds per-player strike counting and a winner output.
module turn_controller
  import turn_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS_PER_SPEEDUP = 4,
  parameter int unsigned LOAD_CYCLES        = 100_000_000,
  parameter int unsigned GUARD_CYCLES       = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       move_valid,
  input  logic       game_over_in,
  input  logic       time_up,
  output logic       timer_reset,
  output logic [1:0] timer_freq,
  output logic       player,
  output logic       loading,
  output logic       forfeit,
  output logic       fast_mode,
  output logic       game_done
`ifdef STRIKE_LIMIT_EN
  ,
  output logic       winner
`endif
);

  localparam int unsigned MC_W    = $clog2(ROUNDS_PER_SPEEDUP + 1);
  localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 2);
  localparam int unsigned LOAD_W  = load_width(LOAD_CYCLES);

  localparam logic [MC_W-1:0]    MC_MAX     = MC_W'(ROUNDS_PER_SPEEDUP);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(GUARD_CYCLES);
  localparam logic [LOAD_W-1:0]  LOAD_INIT  = LOAD_W'(LOAD_CYCLES - 1);

  state_t             r_state;
  logic               r_player;
  logic               r_forfeit;
  logic               r_fast_mode;
  logic [MC_W-1:0]    r_move_cnt;
  logic [GUARD_W-1:0] r_guard;

  logic w_game_over_hit;
  logic w_timeout;
  logic w_third_strike;
  logic w_load_start;
  logic w_load_done;

`ifdef STRIKE_LIMIT_EN
  logic [1:0] r_strikes [2];
  logic       r_winner;

  assign w_third_strike = (r_strikes[r_player] == 2'd2);
  assign winner         = r_winner;
`else
  assign w_third_strike = 1'b0;
`endif

  // game_over_in only matters while a turn is live or pausing; it outranks start.
  assign w_game_over_hit = game_over_in && ((r_state == PLAY) || (r_state == LOAD));
  assign w_timeout       = (r_state == PLAY) && time_up && (r_guard == '0)
                           && !move_valid && !start && !game_over_in;
  assign w_load_start    = w_timeout && !w_third_strike;

  load_timer #(
    .WIDTH(LOAD_W)
  ) u_load_timer (
    .clk       (clk),
    .i_rst     (reset_n),
    .i_load    (w_load_start),
    .i_load_val(LOAD_INIT),
    .i_en      (r_state == LOAD),
    .o_done    (w_load_done)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state     <= IDLE;
      r_player    <= 1'b0;
      r_forfeit   <= 1'b0;
      r_fast_mode <= 1'b0;
      r_move_cnt  <= '0;
      r_guard     <= '0;
`ifdef STRIKE_LIMIT_EN
      r_strikes[0] <= '0;
      r_strikes[1] <= '0;
      r_winner     <= 1'b0;
`endif
    end else begin
      r_forfeit <= 1'b0;
      if (w_game_over_hit) begin
        r_state <= DONE;
`ifdef STRIKE_LIMIT_EN
        r_winner <= ~r_player;
`endif
      end else if (start) begin
        r_state     <= ARM;
        r_player    <= 1'b0;
        r_fast_mode <= 1'b0;
        r_move_cnt  <= '0;
`ifdef STRIKE_LIMIT_EN
        r_strikes[0] <= '0;
        r_strikes[1] <= '0;
`endif
      end else begin
        case (r_state)
          ARM: begin
            r_guard <= GUARD_INIT;
            r_state <= PLAY;
          end
          PLAY: begin
            if (r_guard != '0) r_guard <= r_guard - 1'b1;
            if (move_valid) begin
              r_player <= ~r_player;
              if (r_move_cnt != MC_MAX) r_move_cnt <= r_move_cnt + 1'b1;
              if (32'(r_move_cnt) + 32'd1 >= ROUNDS_PER_SPEEDUP) r_fast_mode <= 1'b1;
              r_state <= ARM;
            end else if (time_up && (r_guard == '0)) begin
              r_forfeit <= 1'b1;
              r_player  <= ~r_player;
              r_state   <= w_third_strike ? DONE : LOAD;
`ifdef STRIKE_LIMIT_EN
              if (r_strikes[r_player] != 2'd3) r_strikes[r_player] <= r_strikes[r_player] + 2'd1;
              if (w_third_strike) r_winner <= ~r_player;
`endif
            end
          end
          LOAD: begin
            if (w_load_done) r_state <= ARM;
          end
          default: ;
        endcase
      end
    end
  end

  assign timer_reset = (r_state != PLAY);
  assign timer_freq  = (r_state == PLAY) ? (r_fast_mode ? FREQ_FAST : FREQ_SLOW) : FREQ_HOLD;
  assign loading     = (r_state == LOAD);
  assign game_done   = (r_state == DONE);
  assign player      = r_player;
  assign forfeit     = r_forfeit;
  assign fast_mode   = r_fast_mode;

endmodule
